// File: rtl/elastic_skp_controller.sv
// Read-side SKP clock-compensation controller for the RX elastic buffer.
// Optional statistics counters are built when ELASTIC_SKP_STATS_EN is defined.
module elastic_skp_controller #(
   parameter int DATA_WIDTH   = 10,
   parameter int BUFFER_DEPTH = 16,
   parameter int HYST         = 2,
   parameter int EMPTY_TARGET = 4,
   parameter int ADDR_W       = $clog2(BUFFER_DEPTH)
) (
   input  logic                  read_clk,
   input  logic                  rst_n,
   input  logic                  buffer_mode,
   input  logic [ADDR_W:0]       fill_level,
   input  logic                  sym_valid,
   input  logic [DATA_WIDTH-1:0] sym_in,
   output logic [1:0]            rd_inc,
   output logic                  skp_added,
   output logic                  skp_removed,
   output logic [7:0]            skp_add_cnt,
   output logic [7:0]            skp_rem_cnt
);

   localparam int FW = ADDR_W + 1;

   localparam int T_HALF  = BUFFER_DEPTH / 2;
   localparam int T_EMPTY = EMPTY_TARGET;
   localparam int LO_HALF_I  = (T_HALF  > HYST) ? T_HALF  - HYST : 1;
   localparam int LO_EMPTY_I = (T_EMPTY > HYST) ? T_EMPTY - HYST : 1;

   localparam logic [FW-1:0] LO_HALF  = FW'(LO_HALF_I);
   localparam logic [FW-1:0] HI_HALF  = FW'(T_HALF + HYST);
   localparam logic [FW-1:0] LO_EMPTY = FW'(LO_EMPTY_I);
   localparam logic [FW-1:0] HI_EMPTY = FW'(T_EMPTY + HYST);
   localparam logic [FW-1:0] MIN_REM_FILL = FW'(2);

   localparam logic [DATA_WIDTH-1:0] COM_N = DATA_WIDTH'(10'h0FA);
   localparam logic [DATA_WIDTH-1:0] COM_P = DATA_WIDTH'(10'h305);
   localparam logic [DATA_WIDTH-1:0] SKP_N = DATA_WIDTH'(10'h0F4);
   localparam logic [DATA_WIDTH-1:0] SKP_P = DATA_WIDTH'(10'h30B);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SEEN_COM = 2'd1;
   localparam logic [1:0] ST_ADJ_DONE = 2'd2;

   localparam logic [1:0] ADJ_NONE = 2'd0;
   localparam logic [1:0] ADJ_ADD  = 2'd1;
   localparam logic [1:0] ADJ_REM  = 2'd2;

   logic [1:0] state_q, state_d;
   logic [1:0] adj_q, adj_d;
   logic       added_q, added_d;
   logic       removed_q, removed_d;
   logic [1:0] rd_inc_c;

   logic          is_com, is_skp;
   logic [FW-1:0] lo_thr, hi_thr;
   logic [1:0]    adj_now;

   assign is_com = (sym_in == COM_N) || (sym_in == COM_P);
   assign is_skp = (sym_in == SKP_N) || (sym_in == SKP_P);
   assign lo_thr = buffer_mode ? LO_EMPTY : LO_HALF;
   assign hi_thr = buffer_mode ? HI_EMPTY : HI_HALF;

   always_comb begin
      adj_now = ADJ_NONE;
      if (fill_level < lo_thr) begin
         adj_now = ADJ_ADD;
      end else if (fill_level > hi_thr) begin
         adj_now = ADJ_REM;
      end
   end

   // Everything freezes while the head is invalid; the pointer is held too.
   always_comb begin
      state_d   = state_q;
      adj_d     = adj_q;
      added_d   = 1'b0;
      removed_d = 1'b0;
      rd_inc_c  = 2'd0;
      if (sym_valid) begin
         rd_inc_c = 2'd1;
         case (state_q)
            ST_IDLE: begin
               if (is_com) begin
                  state_d = ST_SEEN_COM;
                  adj_d   = adj_now;
               end
            end
            ST_SEEN_COM: begin
               if (is_skp) begin
                  state_d = ST_ADJ_DONE;
                  if (adj_q == ADJ_ADD) begin
                     rd_inc_c = 2'd0;
                     added_d  = 1'b1;
                  end else if ((adj_q == ADJ_REM) && (fill_level >= MIN_REM_FILL)) begin
                     rd_inc_c  = 2'd2;
                     removed_d = 1'b1;
                  end
               end else if (is_com) begin
                  adj_d = adj_now;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ADJ_DONE: begin
               if (is_com) begin
                  state_d = ST_SEEN_COM;
                  adj_d   = adj_now;
               end else if (!is_skp) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               adj_d   = ADJ_NONE;
            end
         endcase
      end
   end

   assign rd_inc      = rst_n ? rd_inc_c : 2'd0;
   assign skp_added   = added_q;
   assign skp_removed = removed_q;

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         adj_q     <= ADJ_NONE;
         added_q   <= 1'b0;
         removed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         adj_q     <= adj_d;
         added_q   <= added_d;
         removed_q <= removed_d;
      end
   end

`ifdef ELASTIC_SKP_STATS_EN
   logic [7:0] add_cnt_q, add_cnt_d;
   logic [7:0] rem_cnt_q, rem_cnt_d;

   always_comb begin
      add_cnt_d = add_cnt_q;
      rem_cnt_d = rem_cnt_q;
      if (added_d && (add_cnt_q != 8'hFF)) begin
         add_cnt_d = add_cnt_q + 8'd1;
      end
      if (removed_d && (rem_cnt_q != 8'hFF)) begin
         rem_cnt_d = rem_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         add_cnt_q <= '0;
         rem_cnt_q <= '0;
      end else begin
         add_cnt_q <= add_cnt_d;
         rem_cnt_q <= rem_cnt_d;
      end
   end

   assign skp_add_cnt = add_cnt_q;
   assign skp_rem_cnt = rem_cnt_q;
`else
   assign skp_add_cnt = 8'h00;
   assign skp_rem_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_elastic_skp_controller.sv
// Scoreboard bench for elastic_skp_controller: directed head-symbol vectors
// with hand-computed per-cycle rd_inc / pulse / counter expectations.
module tb_elastic_skp_controller;

   logic       clk;
   logic       rst_n;
   logic       buffer_mode;
   logic [4:0] fill_level;
   logic       sym_valid;
   logic [9:0] sym_in;
   logic [1:0] rd_inc;
   logic       skp_added;
   logic       skp_removed;
   logic [7:0] skp_add_cnt;
   logic [7:0] skp_rem_cnt;

   elastic_skp_controller #(
      .DATA_WIDTH  (10),
      .BUFFER_DEPTH(16),
      .HYST        (2),
      .EMPTY_TARGET(4)
   ) dut (
      .read_clk   (clk),
      .rst_n      (rst_n),
      .buffer_mode(buffer_mode),
      .fill_level (fill_level),
      .sym_valid  (sym_valid),
      .sym_in     (sym_in),
      .rd_inc     (rd_inc),
      .skp_added  (skp_added),
      .skp_removed(skp_removed),
      .skp_add_cnt(skp_add_cnt),
      .skp_rem_cnt(skp_rem_cnt)
   );

   localparam logic [9:0] D  = 10'h1BC;
   localparam logic [9:0] C0 = 10'h0FA;
   localparam logic [9:0] C1 = 10'h305;
   localparam logic [9:0] S0 = 10'h0F4;
   localparam logic [9:0] S1 = 10'h30B;

   typedef struct {
      int         idx;
      logic [1:0] rd;
      logic       add;
      logic       rem;
      logic [7:0] cadd;
      logic [7:0] crem;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   vec_idx  = 0;
   int   m_add    = 0;
   int   m_rem    = 0;
   bit   stim_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input int got, input int want);
      n_checks++;
      if (got == want) begin
         n_pass++;
      end else begin
         $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, got, want);
      end
   endtask

   // Drive one head-symbol cycle and queue what the DUT must show during it.
   task automatic step(input bit r, input bit vld, input logic [9:0] s, input int f,
                       input bit m, input int rd, input bit a, input bit rm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n       = r;
      sym_valid   = vld;
      sym_in      = s;
      fill_level  = 5'(f);
      buffer_mode = m;
      if (!r) begin
         m_add = 0;
         m_rem = 0;
      end else begin
         if (a && m_add < 255) m_add++;
         if (rm && m_rem < 255) m_rem++;
      end
      e.idx = vec_idx++;
      e.rd  = 2'(rd);
      e.add = a;
      e.rem = rm;
`ifdef ELASTIC_SKP_STATS_EN
      e.cadd = 8'(m_add);
      e.crem = 8'(m_rem);
`else
      e.cadd = 8'h00;
      e.crem = 8'h00;
`endif
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("rd_inc", e.idx, int'(rd_inc), int'(e.rd));
         check("skp_added", e.idx, int'(skp_added), int'(e.add));
         check("skp_removed", e.idx, int'(skp_removed), int'(e.rem));
         check("skp_add_cnt", e.idx, int'(skp_add_cnt), int'(e.cadd));
         check("skp_rem_cnt", e.idx, int'(skp_rem_cnt), int'(e.crem));
      end
   end

   initial begin
      rst_n = 1'b0; sym_valid = 1'b0; sym_in = D; fill_level = 5'd8; buffer_mode = 1'b0;
      // reset state
      step(0, 1, D, 8, 0, 0, 0, 0);
      step(0, 1, S0, 5, 0, 0, 0, 0);
      // mode0 fill 5: insert (held SKP re-presented)
      step(1, 1, D,  5, 0, 1, 0, 0);
      step(1, 1, C0, 5, 0, 1, 0, 0);
      step(1, 1, S0, 5, 0, 0, 0, 0);
      step(1, 1, S0, 5, 0, 1, 1, 0);
      step(1, 1, S0, 5, 0, 1, 0, 0);
      step(1, 1, S0, 5, 0, 1, 0, 0);
      step(1, 1, D,  5, 0, 1, 0, 0);
      // mode0 fill 11: remove, other disparity
      step(1, 1, D,  11, 0, 1, 0, 0);
      step(1, 1, C1, 11, 0, 1, 0, 0);
      step(1, 1, S1, 11, 0, 2, 0, 0);
      step(1, 1, S1, 11, 0, 1, 0, 1);
      step(1, 1, D,  11, 0, 1, 0, 0);
      // mode0 boundaries fill 6 (=LO) and 10 (=HI): no adjust
      step(1, 1, C0, 6, 0, 1, 0, 0);
      step(1, 1, S0, 6, 0, 1, 0, 0);
      step(1, 1, S0, 6, 0, 1, 0, 0);
      step(1, 1, D,  6, 0, 1, 0, 0);
      step(1, 1, C0, 10, 0, 1, 0, 0);
      step(1, 1, S0, 10, 0, 1, 0, 0);
      step(1, 1, S0, 10, 0, 1, 0, 0);
      step(1, 1, D,  10, 0, 1, 0, 0);
      // mode1: fill 4 none, fill 7 remove, fill 1 add, fill 2 (=LO) none
      step(1, 1, C0, 4, 1, 1, 0, 0);
      step(1, 1, S0, 4, 1, 1, 0, 0);
      step(1, 1, S0, 4, 1, 1, 0, 0);
      step(1, 1, S0, 4, 1, 1, 0, 0);
      step(1, 1, C0, 7, 1, 1, 0, 0);
      step(1, 1, S0, 7, 1, 2, 0, 0);
      step(1, 1, S0, 7, 1, 1, 0, 1);
      step(1, 1, D,  7, 1, 1, 0, 0);
      step(1, 1, C0, 1, 1, 1, 0, 0);
      step(1, 1, S0, 1, 1, 0, 0, 0);
      step(1, 1, S0, 1, 1, 1, 1, 0);
      step(1, 1, S0, 1, 1, 1, 0, 0);
      step(1, 1, S0, 1, 1, 1, 0, 0);
      step(1, 1, D,  1, 1, 1, 0, 0);
      step(1, 1, C0, 2, 1, 1, 0, 0);
      step(1, 1, S0, 2, 1, 1, 0, 0);
      step(1, 1, D,  2, 1, 1, 0, 0);
      // remove suppressed when fill drops below 2 at the SKP
      step(1, 1, C0, 7, 1, 1, 0, 0);
      step(1, 1, S0, 1, 1, 1, 0, 0);
      step(1, 1, S0, 1, 1, 1, 0, 0);
      step(1, 1, D,  1, 1, 1, 0, 0);
      // back-to-back COM re-latches; mode change after COM ignored
      step(1, 1, C0, 5, 0, 1, 0, 0);
      step(1, 1, C0, 8, 0, 1, 0, 0);
      step(1, 1, S0, 8, 0, 1, 0, 0);
      step(1, 1, D,  8, 0, 1, 0, 0);
      step(1, 1, C0, 5, 0, 1, 0, 0);
      step(1, 1, S0, 5, 1, 0, 0, 0);
      step(1, 1, S0, 5, 1, 1, 1, 0);
      step(1, 1, D,  5, 1, 1, 0, 0);
      // sym_valid low inside the ordered set
      step(1, 0, D,  5, 0, 0, 0, 0);
      step(1, 1, C0, 5, 0, 1, 0, 0);
      step(1, 0, S0, 9, 0, 0, 0, 0);
      step(1, 0, S0, 9, 0, 0, 0, 0);
      step(1, 0, S0, 9, 0, 0, 0, 0);
      step(1, 1, S0, 5, 0, 0, 0, 0);
      step(1, 1, S0, 5, 0, 1, 1, 0);
      step(1, 1, S0, 5, 0, 1, 0, 0);
      step(1, 1, S0, 5, 0, 1, 0, 0);
      step(1, 1, D,  5, 0, 1, 0, 0);
      // reset in SEEN_COM with ADD pending
      step(1, 1, D,  5, 0, 1, 0, 0);
      step(1, 1, C0, 5, 0, 1, 0, 0);
      step(0, 1, S0, 5, 0, 0, 0, 0);
      step(1, 1, S0, 5, 0, 1, 0, 0);
      step(1, 1, S0, 5, 0, 1, 0, 0);
      step(1, 1, D,  5, 0, 1, 0, 0);
      // 300 forced inserts: counter saturates (stats build) or stays 0
      for (int i = 0; i < 300; i++) begin
         step(1, 1, C0, 5, 0, 1, 0, 0);
         step(1, 1, S0, 5, 0, 0, 0, 0);
         step(1, 1, S0, 5, 0, 1, 1, 0);
      end
      step(1, 1, D, 5, 0, 1, 0, 0);
      step(1, 1, D, 5, 0, 1, 0, 0);
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
